// File: rtl/recursive_datapath_pkg.sv
// Shared encodings for the recursive-computation datapath and its controller.
// Holds write-target, operand-select and ALU-op encodings plus small decode helpers.
package recursive_datapath_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_MULT  = 14;

  typedef enum logic [1:0] {
    WSEL_A    = 2'b00,
    WSEL_B    = 2'b01,
    WSEL_N    = 2'b10,
    WSEL_NONE = 2'b11
  } wsel_e;

  typedef enum logic [1:0] {
    OSEL_A    = 2'b00,
    OSEL_B    = 2'b01,
    OSEL_N    = 2'b10,
    OSEL_ZERO = 2'b11
  } osel_e;

  typedef enum logic [1:0] {
    ALU_INC  = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_MUL  = 2'b10,
    ALU_PASS = 2'b11
  } alu_e;

  // A write to b arms the result-capture check for the following cycle.
  function automatic logic is_b_write(input logic wen, input logic [1:0] wsel);
    return wen && (wsel == WSEL_B);
  endfunction

  function automatic logic is_reg_write(input logic wen, input logic [1:0] wsel);
    return wen && (wsel != WSEL_NONE);
  endfunction

endpackage

// File: rtl/recursive_datapath_alu.sv
// Combinational ALU: X+1, a+b, a*MULT or pass-through of data, truncated to WIDTH.
// carry_out flags a true result that does not fit in WIDTH bits.
module recursive_alu
  import recursive_datapath_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MULT  = DEFAULT_MULT
) (
  input  logic [1:0]       osel,
  input  logic [1:0]       alusel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out
);

  localparam logic [2*WIDTH-1:0] MULT_WIDE = (2*WIDTH)'(MULT);

  logic [WIDTH-1:0]   x;
  logic [WIDTH:0]     inc_sum;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    x = '0;
    case (osel)
      OSEL_A:  x = a;
      OSEL_B:  x = b;
      OSEL_N:  x = n;
      default: x = '0;
    endcase
  end

  assign inc_sum = {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
  assign add_sum = {1'b0, a} + {1'b0, b};
  // Full-width product so the high half can report overflow.
  assign product = {{WIDTH{1'b0}}, a} * MULT_WIDE;

  always_comb begin
    alu_out   = '0;
    carry_out = 1'b0;
    case (alusel)
      ALU_INC: begin
        alu_out   = inc_sum[WIDTH-1:0];
        carry_out = inc_sum[WIDTH];
      end
      ALU_ADD: begin
        alu_out   = add_sum[WIDTH-1:0];
        carry_out = add_sum[WIDTH];
      end
      ALU_MUL: begin
        alu_out   = product[WIDTH-1:0];
        carry_out = |product[2*WIDTH-1:WIDTH];
      end
      default: begin
        alu_out   = data;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/recursive_datapath.sv
// Datapath for the recursive a(k) = a(k-1)*MULT + k controller: registers a, b, n, flag z,
// first-wins result capture. Define RECURSIVE_DATAPATH_OVF_EN to enable the sticky ovf flag.
module recursive_datapath
  import recursive_datapath_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MULT  = DEFAULT_MULT
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wen,
  input  logic [1:0]       wsel,
  input  logic [1:0]       osel,
  input  logic [1:0]       alusel,
  input  logic [WIDTH-1:0] data,
  output logic             z,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             ovf
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] n;
  logic             wb_d;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             capture;

  recursive_alu #(
    .WIDTH(WIDTH),
    .MULT (MULT)
  ) u_alu (
    .osel     (osel),
    .alusel   (alusel),
    .a        (a),
    .b        (b),
    .n        (n),
    .data     (data),
    .alu_out  (alu_out),
    .carry_out(alu_carry)
  );

  assign z = (b == n);

  // Capture only in the idle cycle right after a b write; once valid, later matches are ignored.
  assign capture = wb_d && !wen && z && !res_valid;

  always_ff @(posedge clk) begin
    if (res) begin
      a         <= '0;
      b         <= '0;
      n         <= '0;
      wb_d      <= 1'b0;
      result    <= '0;
      res_valid <= 1'b0;
    end else begin
      if (wen) begin
        case (wsel)
          WSEL_A:  a <= alu_out;
          WSEL_B:  b <= alu_out;
          WSEL_N:  n <= alu_out;
          default: ;
        endcase
      end
      wb_d <= is_b_write(wen, wsel);
      if (capture) begin
        result    <= a;
        res_valid <= 1'b1;
      end
    end
  end

`ifdef RECURSIVE_DATAPATH_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (res) begin
      ovf_q <= 1'b0;
    end else if (is_reg_write(wen, wsel) && alu_carry) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  logic carry_unused;

  assign carry_unused = alu_carry;
  assign ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_recursive_datapath.sv
// Scoreboarded bench for recursive_datapath: drives controller-style op sequences against a
// reference model, plus an 8-bit instance for the wrap/overflow case.
module tb_recursive_datapath;
  import recursive_datapath_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] n;
    logic [W-1:0] result;
    logic         valid;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         res = 1'b1;
  logic         wen = 1'b0;
  logic [1:0]   wsel = 2'b11;
  logic [1:0]   osel = 2'b11;
  logic [1:0]   alusel = 2'b00;
  logic [W-1:0] data = '0;
  logic         z;
  logic [W-1:0] result;
  logic         res_valid;
  logic         ovf;

  logic         res8 = 1'b1;
  logic         wen8 = 1'b0;
  logic [1:0]   wsel8 = 2'b11;
  logic [1:0]   osel8 = 2'b11;
  logic [1:0]   alusel8 = 2'b00;
  logic [7:0]   data8 = '0;
  logic         z8;
  logic [7:0]   result8;
  logic         valid8;
  logic         ovf8;

  recursive_datapath #(.WIDTH(W), .MULT(14)) dut (
    .clk(clk), .res(res), .wen(wen), .wsel(wsel), .osel(osel), .alusel(alusel),
    .data(data), .z(z), .result(result), .res_valid(res_valid), .ovf(ovf)
  );

  recursive_datapath #(.WIDTH(8), .MULT(14)) dut8 (
    .clk(clk), .res(res8), .wen(wen8), .wsel(wsel8), .osel(osel8), .alusel(alusel8),
    .data(data8), .z(z8), .result(result8), .res_valid(valid8), .ovf(ovf8)
  );

  int    assertCount = 0;
  int    failCount   = 0;
  string phase = "init";

  logic [W-1:0] ma, mb, mn, mres;
  logic         mwb, mvalid, movf;
  exp_t         sbQueue[$];

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
    assertCount++;
    if (got !== expv) begin
      failCount++;
      $display("[TB] FAIL %s.%s: got 0x%0h expected 0x%0h", phase, tag, got, expv);
    end
  endtask

  task automatic modelReset();
    ma = '0; mb = '0; mn = '0; mres = '0;
    mwb = 1'b0; mvalid = 1'b0; movf = 1'b0;
  endtask

  // Reference behaviour: compute the post-edge state and queue it for comparison.
  task automatic modelStep(input logic r, input logic w, input logic [1:0] ws,
                           input logic [1:0] os, input logic [1:0] as, input logic [W-1:0] d);
    logic [W-1:0]   x;
    logic [2*W-1:0] full;
    if (r) begin
      modelReset();
    end else begin
      case (os)
        2'b00:   x = ma;
        2'b01:   x = mb;
        2'b10:   x = mn;
        default: x = '0;
      endcase
      case (as)
        2'b00:   full = {{W{1'b0}}, x} + 64'd1;
        2'b01:   full = {{W{1'b0}}, ma} + {{W{1'b0}}, mb};
        2'b10:   full = {{W{1'b0}}, ma} * 64'd14;
        default: full = {{W{1'b0}}, d};
      endcase
      if (mwb && !w && (mb == mn) && !mvalid) begin
        mres   = ma;
        mvalid = 1'b1;
      end
`ifdef RECURSIVE_DATAPATH_OVF_EN
      if (w && ws != 2'b11 && full[2*W-1:W] != '0) movf = 1'b1;
`endif
      if (w) begin
        case (ws)
          2'b00:   ma = full[W-1:0];
          2'b01:   mb = full[W-1:0];
          2'b10:   mn = full[W-1:0];
          default: ;
        endcase
      end
      mwb = w && (ws == 2'b01);
    end
    sbQueue.push_back('{a: ma, b: mb, n: mn, result: mres, valid: mvalid, ovf: movf});
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [1:0] ws,
                               input logic [1:0] os, input logic [1:0] as, input logic [W-1:0] d);
    exp_t e;
    res = r; wen = w; wsel = ws; osel = os; alusel = as; data = d;
    checkOutput("z", {31'b0, z}, {31'b0, (mb == mn)});
    modelStep(r, w, ws, os, as, d);
    @(posedge clk);
    #1;
    e = sbQueue.pop_front();
    checkOutput("a", dut.a, e.a);
    checkOutput("b", dut.b, e.b);
    checkOutput("n", dut.n, e.n);
    checkOutput("result", result, e.result);
    checkOutput("res_valid", {31'b0, res_valid}, {31'b0, e.valid});
    checkOutput("ovf", {31'b0, ovf}, {31'b0, e.ovf});
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, WSEL_A, OSEL_ZERO, ALU_INC, '0);
    res = 1'b0;
  endtask

  task automatic runSetup(input int nval);
    applyStimulus(1'b0, 1'b1, WSEL_B, OSEL_ZERO, ALU_INC, '0);
    applyStimulus(1'b0, 1'b1, WSEL_N, OSEL_ZERO, ALU_PASS, W'(nval));
    applyStimulus(1'b0, 1'b1, WSEL_N, OSEL_N, ALU_INC, '0);
  endtask

  task automatic runIteration(input logic withWait);
    applyStimulus(1'b0, 1'b1, WSEL_A, OSEL_ZERO, ALU_MUL, '0);
    applyStimulus(1'b0, 1'b1, WSEL_A, OSEL_ZERO, ALU_ADD, '0);
    applyStimulus(1'b0, 1'b1, WSEL_B, OSEL_B, ALU_INC, '0);
    if (withWait) applyStimulus(1'b0, 1'b0, WSEL_NONE, OSEL_ZERO, ALU_INC, '0);
  endtask

  task automatic runRecursion(input int nval, input int iters);
    runSetup(nval);
    for (int k = 0; k < iters; k++) runIteration(1'b1);
    applyStimulus(1'b0, 1'b0, WSEL_NONE, OSEL_ZERO, ALU_INC, '0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    @(posedge clk);
    #1;
    phase = "reset";
    doReset();
    checkOutput("reset_z", {31'b0, z}, 32'd1);

    phase = "n3";
    runRecursion(3, 3);
    checkOutput("final_result", result, 32'd227);
    checkOutput("final_valid", {31'b0, res_valid}, 32'd1);

    phase = "n1";
    doReset();
    runRecursion(1, 1);
    checkOutput("final_result", result, 32'd1);

    phase = "midreset";
    doReset();
    runSetup(5);
    runIteration(1'b1);
    runIteration(1'b0);
    doReset();
    checkOutput("a_cleared", dut.a, 32'd0);
    checkOutput("valid_cleared", {31'b0, res_valid}, 32'd0);

    phase = "n2";
    runRecursion(2, 2);
    checkOutput("final_result", result, 32'd16);

    phase = "hold";
    applyStimulus(1'b0, 1'b1, WSEL_N, OSEL_ZERO, ALU_PASS, 32'd7);
    applyStimulus(1'b0, 1'b1, WSEL_B, OSEL_ZERO, ALU_PASS, 32'd7);
    applyStimulus(1'b0, 1'b1, WSEL_A, OSEL_ZERO, ALU_PASS, 32'h0000_DEAD);
    applyStimulus(1'b0, 1'b0, WSEL_NONE, OSEL_ZERO, ALU_INC, '0);
    checkOutput("a_dead", dut.a, 32'h0000_DEAD);
    checkOutput("held_result", result, 32'd16);
    checkOutput("held_valid", {31'b0, res_valid}, 32'd1);

    phase = "nowrite";
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, WSEL_NONE, OSEL_A, 2'(i), 32'd5);

    phase = "n0";
    doReset();
    runRecursion(0, 3);
    checkOutput("never_valid", {31'b0, res_valid}, 32'd0);

    phase = "w8";
    res8 = 1'b1;
    @(posedge clk); #1;
    res8 = 1'b0; wen8 = 1'b1; wsel8 = WSEL_A; alusel8 = ALU_PASS; data8 = 8'h20;
    @(posedge clk); #1;
    checkOutput("a_load", {24'b0, dut8.a}, 32'h20);
    alusel8 = ALU_MUL;
    @(posedge clk); #1;
    checkOutput("a_wrap", {24'b0, dut8.a}, 32'hC0);
`ifdef RECURSIVE_DATAPATH_OVF_EN
    checkOutput("ovf_set", {31'b0, ovf8}, 32'd1);
`else
    checkOutput("ovf_set", {31'b0, ovf8}, 32'd0);
`endif
    wsel8 = WSEL_NONE;
    @(posedge clk); #1;
    checkOutput("a_kept", {24'b0, dut8.a}, 32'hC0);
`ifdef RECURSIVE_DATAPATH_OVF_EN
    checkOutput("ovf_sticky", {31'b0, ovf8}, 32'd1);
`else
    checkOutput("ovf_sticky", {31'b0, ovf8}, 32'd0);
`endif
    res8 = 1'b1; wen8 = 1'b0;
    @(posedge clk); #1;
    checkOutput("ovf_reset", {31'b0, ovf8}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
